// File: rtl/fdiv_d_post_if.sv
// fdiv_d_post_if: divider-to-post-normaliser operand bus and packed result bus
interface fdiv_d_post_if;
   logic         i_valid;
   logic [104:0] i_result;
   logic [6:0]   i_lshift;
   logic         i_overflow;
   logic         i_zero_resid;
   logic         i_sign;
   logic [12:0]  i_exp_dif;
   logic         i_nan;
   logic         i_inf;
   logic         i_zero;
   logic         i_divbyzero;
   logic         o_valid;
   logic [63:0]  o_res;
   logic         o_ex_inexact;
   logic         o_ex_overflow;
   logic         o_ex_underflow;
   logic         o_ex_divbyzero;
   logic         o_busy;
   modport master (
      output i_valid, i_result, i_lshift, i_overflow, i_zero_resid, i_sign,
             i_exp_dif, i_nan, i_inf, i_zero, i_divbyzero,
      input  o_valid, o_res, o_ex_inexact, o_ex_overflow, o_ex_underflow,
             o_ex_divbyzero, o_busy
   );
   modport slave (
      input  i_valid, i_result, i_lshift, i_overflow, i_zero_resid, i_sign,
             i_exp_dif, i_nan, i_inf, i_zero, i_divbyzero,
      output o_valid, o_res, o_ex_inexact, o_ex_overflow, o_ex_underflow,
             o_ex_divbyzero, o_busy
   );
endinterface

// File: rtl/fdiv_d_post.sv
// fdiv_d_post: 3-stage normalise / round-nearest-even / pack stage of the double divider
module fdiv_d_post #(
   parameter logic async_reset = 1'b1
) (
   input logic          i_clk,
   input logic          i_rst,
   fdiv_d_post_if.slave bus
);
   if (!async_reset) begin : g_sync_unsupported
   end
   logic [104:0] sh;
   logic [13:0]  e1;
   logic         s1_v, s1_st, s1_sign, s1_nan, s1_inf, s1_zero, s1_dbz;
   logic [53:0]  s1_m;
   logic [13:0]  s1_e;
   logic         s2_v, s2_inx, s2_sign, s2_nan, s2_inf, s2_zero, s2_dbz;
   logic [51:0]  s2_frac;
   logic [13:0]  s2_e;
   logic         g, inc, c, carry;
   logic [51:0]  f;
   logic         ge, le, special;
   logic [63:0]  res;
   logic [3:0]   fl;
   assign sh = bus.i_result << bus.i_lshift;
   assign e1 = {bus.i_exp_dif[12], bus.i_exp_dif} - {7'b0, bus.i_lshift};
   // S1: normalise the quotient so the leading one lands on bit 104, fold low bits into sticky
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_v    <= 1'b0;
         s1_m    <= '0;
         s1_st   <= 1'b0;
         s1_e    <= '0;
         s1_sign <= 1'b0;
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
         s1_zero <= 1'b0;
         s1_dbz  <= 1'b0;
      end else begin
         s1_v    <= bus.i_valid;
         s1_m    <= sh[104:51];
         s1_st   <= |sh[50:0] | ~bus.i_zero_resid;
         s1_e    <= e1;
         s1_sign <= bus.i_sign;
         s1_nan  <= bus.i_nan;
         s1_inf  <= bus.i_inf;
         s1_zero <= bus.i_zero | bus.i_overflow;
         s1_dbz  <= bus.i_divbyzero;
      end
   end
   assign g     = s1_m[0];
   assign inc   = g & (s1_st | s1_m[1]);
   assign {c, f} = {1'b0, s1_m[52:1]} + {52'b0, inc};
   // a carry out of the fraction only bumps the exponent when the integer bit was set
   assign carry = c & s1_m[53];
   // S2: round to nearest-even; a full carry leaves fraction 0 and bumps the exponent
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_v    <= 1'b0;
         s2_frac <= '0;
         s2_e    <= '0;
         s2_inx  <= 1'b0;
         s2_sign <= 1'b0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
         s2_dbz  <= 1'b0;
      end else begin
         s2_v    <= s1_v;
         s2_frac <= f;
         s2_e    <= s1_e + {13'b0, carry};
         s2_inx  <= g | s1_st;
         s2_sign <= s1_sign;
         s2_nan  <= s1_nan;
         s2_inf  <= s1_inf;
         s2_zero <= s1_zero;
         s2_dbz  <= s1_dbz;
      end
   end
   assign ge      = $signed(s2_e) >= 14'sd2047;
   assign le      = $signed(s2_e) < 14'sd1;
   assign special = s2_nan | s2_dbz | s2_inf | s2_zero;
   // S3 classification: specials first, then exponent range, denormals flush to zero
   always_comb begin
      res = s2_nan            ? 64'h7FF8000000000000 :
            (s2_dbz | s2_inf) ? {s2_sign, 11'h7FF, 52'h0} :
            s2_zero           ? {s2_sign, 63'h0} :
            ge                ? {s2_sign, 11'h7FF, 52'h0} :
            le                ? {s2_sign, 63'h0} :
                                {s2_sign, s2_e[10:0], s2_frac};
      fl  = {~special & (ge | le | s2_inx), ~special & ge, ~special & ~ge & le, ~s2_nan & s2_dbz};
   end
   // S3: result and flags load only with a valid entry and hold otherwise
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bus.o_valid        <= 1'b0;
         bus.o_res          <= '0;
         bus.o_ex_inexact   <= 1'b0;
         bus.o_ex_overflow  <= 1'b0;
         bus.o_ex_underflow <= 1'b0;
         bus.o_ex_divbyzero <= 1'b0;
      end else begin
         bus.o_valid <= s2_v;
         if (s2_v) begin
            bus.o_res <= res;
            {bus.o_ex_inexact, bus.o_ex_overflow, bus.o_ex_underflow, bus.o_ex_divbyzero} <= fl;
         end
      end
   end
   assign bus.o_busy = s1_v | s2_v | bus.o_valid;
endmodule

// File: tb/tb_fdiv_d_post.sv
// tb_fdiv_d_post: directed vector table plus pipelining and reset sequences
module tb_fdiv_d_post;
   typedef struct {
      logic [104:0] result;
      logic [6:0]   lshift;
      logic         ovf;
      logic         zr;
      logic         sign;
      logic [12:0]  expd;
      logic         nan;
      logic         inf;
      logic         zero;
      logic         dbz;
      logic [63:0]  res;
      logic [3:0]   fl;
   } vec_t;
   localparam logic [104:0] ONE = 105'd1 << 104;
   localparam logic [104:0] HALF = 105'd1 << 103;
   localparam logic [104:0] ALL1 = {{54{1'b1}}, 51'b0};
   localparam int NV = 18;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[NV];
   fdiv_d_post_if intf();
   fdiv_d_post dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (intf.slave)
   );
   always #5 i_clk = ~i_clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask
   task automatic drive(input vec_t v, input logic vld);
      intf.i_valid      = vld;
      intf.i_result     = v.result;
      intf.i_lshift     = v.lshift;
      intf.i_overflow   = v.ovf;
      intf.i_zero_resid = v.zr;
      intf.i_sign       = v.sign;
      intf.i_exp_dif    = v.expd;
      intf.i_nan        = v.nan;
      intf.i_inf        = v.inf;
      intf.i_zero       = v.zero;
      intf.i_divbyzero  = v.dbz;
   endtask
   function automatic logic [3:0] flags();
      return {intf.o_ex_inexact, intf.o_ex_overflow, intf.o_ex_underflow, intf.o_ex_divbyzero};
   endfunction
   task automatic run_vec(input int i);
      int lat;
      @(posedge i_clk); #1;
      drive(vecs[i], 1'b1);
      @(posedge i_clk); #1;
      intf.i_valid = 1'b0;
      chk($sformatf("busy[%0d]", i), {63'b0, intf.o_busy}, 64'd1);
      lat = 1;
      while (!intf.o_valid && lat < 10) begin
         @(posedge i_clk); #1;
         lat++;
      end
      chk($sformatf("latency[%0d]", i), 64'(lat), 64'd3);
      chk($sformatf("res[%0d]", i), intf.o_res, vecs[i].res);
      chk($sformatf("flags[%0d]", i), {60'b0, flags()}, {60'b0, vecs[i].fl});
      @(posedge i_clk); #1;
      chk($sformatf("pulse[%0d]", i), {63'b0, intf.o_valid}, 64'd0);
      chk($sformatf("hold[%0d]", i), intf.o_res, vecs[i].res);
   endtask
   initial begin
      // fields: result, lshift, ovf, zr, sign, expd, nan, inf, zero, dbz, res, {inexact,overflow,underflow,divbyzero}
      vecs[0]  = '{ONE, 7'd0, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0000000000000, 4'b0000};
      vecs[1]  = '{HALF, 7'd1, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FE0000000000000, 4'b0000};
      vecs[2]  = '{ONE | (105'd1 << 51), 7'd0, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0000000000000, 4'b1000};
      vecs[3]  = '{ONE | (105'd3 << 51), 7'd0, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0000000000002, 4'b1000};
      vecs[4]  = '{ALL1, 7'd0, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4000000000000000, 4'b1000};
      vecs[5]  = '{ONE, 7'd0, 1'b0, 1'b1, 1'b0, 13'd2047, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FF0000000000000, 4'b1100};
      vecs[6]  = '{HALF, 7'd1, 1'b0, 1'b1, 1'b1, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, 4'b1010};
      vecs[7]  = '{ONE, 7'd0, 1'b0, 1'b1, 1'b1, 13'd1023, 1'b1, 1'b0, 1'b0, 1'b0, 64'h7FF8000000000000, 4'b0000};
      vecs[8]  = '{ONE, 7'd0, 1'b0, 1'b1, 1'b1, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFF0000000000000, 4'b0001};
      vecs[9]  = '{ONE, 7'd0, 1'b0, 1'b1, 1'b1, 13'd1023, 1'b1, 1'b0, 1'b0, 1'b1, 64'h7FF8000000000000, 4'b0000};
      vecs[10] = '{ONE, 7'd0, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b1, 1'b0, 1'b0, 64'h7FF0000000000000, 4'b0000};
      vecs[11] = '{ONE, 7'd0, 1'b0, 1'b1, 1'b1, 13'd1023, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000000000000000, 4'b0000};
      vecs[12] = '{105'd0, 7'd120, 1'b1, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000000000000000, 4'b0000};
      vecs[13] = '{ONE, 7'd0, 1'b0, 1'b0, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0000000000000, 4'b1000};
      vecs[14] = '{ONE, 7'd0, 1'b0, 1'b1, 1'b0, 13'd1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0010000000000000, 4'b0000};
      vecs[15] = '{ONE, 7'd0, 1'b0, 1'b1, 1'b0, 13'd2046, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FE0000000000000, 4'b0000};
      vecs[16] = '{ALL1, 7'd0, 1'b0, 1'b1, 1'b1, 13'd2046, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFF0000000000000, 4'b1100};
      vecs[17] = '{ONE | (105'd1 << 51) | 105'd1, 7'd0, 1'b0, 1'b1, 1'b0, 13'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0000000000001, 4'b1000};
      drive(vecs[0], 1'b0);
      #2;
      chk("reset_valid", {63'b0, intf.o_valid}, 64'd0);
      chk("reset_res", intf.o_res, 64'd0);
      chk("reset_flags", {60'b0, flags()}, 64'd0);
      chk("reset_busy", {63'b0, intf.o_busy}, 64'd0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < NV; i++) run_vec(i);
      // four back-to-back entries must emerge on four consecutive cycles
      @(posedge i_clk); #1;
      drive(vecs[0], 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(posedge i_clk); #1;
         if (k < 4) drive(vecs[k], 1'b1);
         else intf.i_valid = 1'b0;
         chk($sformatf("b2b_valid[%0d]", k), {63'b0, intf.o_valid}, {63'b0, k >= 3 && k <= 6});
         if (k >= 3 && k <= 6) begin
            chk($sformatf("b2b_res[%0d]", k), intf.o_res, vecs[k-3].res);
            chk($sformatf("b2b_flags[%0d]", k), {60'b0, flags()}, {60'b0, vecs[k-3].fl});
         end
      end
      // reset one cycle after issue discards the entry immediately
      @(posedge i_clk); #1;
      drive(vecs[5], 1'b1);
      @(posedge i_clk); #1;
      intf.i_valid = 1'b0;
      chk("pre_rst_busy", {63'b0, intf.o_busy}, 64'd1);
      #2;
      i_rst = 1'b1;
      #1;
      chk("mid_rst_valid", {63'b0, intf.o_valid}, 64'd0);
      chk("mid_rst_res", intf.o_res, 64'd0);
      chk("mid_rst_flags", {60'b0, flags()}, 64'd0);
      chk("mid_rst_busy", {63'b0, intf.o_busy}, 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (6) begin
            @(posedge i_clk); #1;
            seen = seen | intf.o_valid;
         end
         chk("post_rst_no_valid", {63'b0, seen}, 64'd0);
         chk("post_rst_res", intf.o_res, 64'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
